// File: rtl/data_mem_io.sv
`default_nettype none
// data_mem_io: CPU data-memory responder with a word RAM and a memory-mapped LED/switch/timer window.
// Read data is combinational from the address; every write commits on the rising clock edge.
module data_mem_io #(
  parameter int          ADDR_W     = 14,
  parameter logic [31:0] IO_BASE    = 32'hFFFFFC00,
  parameter logic [19:0] DEB_CYCLES = 20'd1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ram_wen_w,
  input  logic [31:0] ram_adr_i_w,
  input  logic [31:0] ram_dat_i_w,
  output logic [31:0] ram_dat_o_w,
  input  logic [15:0] sw_i,
  output logic [15:0] led_o,
  output logic        tmr_ovf_o
);

  localparam logic [31:0] LED_ADR  = IO_BASE + 32'h60;
  localparam logic [31:0] SW_ADR   = IO_BASE + 32'h70;
  localparam logic [31:0] TMR_ADR  = IO_BASE + 32'h80;
  localparam logic [31:0] STAT_ADR = IO_BASE + 32'h84;

  typedef enum logic [0:0] {
    STABLE   = 1'b0,
    COUNTING = 1'b1
  } deb_state_t;

  logic [31:0]       mem [0:(1<<ADDR_W)-1];
  logic              io_sel;
  logic [ADDR_W-1:0] ram_idx;
  logic              ram_we;
  logic              led_we;
  logic              tmr_we;
  logic              stat_we;
  logic              tmr_wrap;
  logic [31:0]       timer;
  logic [15:0]       sync1;
  logic [15:0]       sync2;
  logic [15:0]       cand;
  logic [15:0]       sw_reg;
  logic [19:0]       cnt;
  logic [19:0]       cnt_next;
  logic              deb_done;
  deb_state_t        state;

  assign io_sel   = (ram_adr_i_w >= IO_BASE);
  assign ram_idx  = ram_adr_i_w[ADDR_W+1:2];
  assign ram_we   = reset && ram_wen_w && !io_sel;
  assign led_we   = ram_wen_w && (ram_adr_i_w == LED_ADR);
  assign tmr_we   = ram_wen_w && (ram_adr_i_w == TMR_ADR);
  assign stat_we  = ram_wen_w && (ram_adr_i_w == STAT_ADR);
  assign tmr_wrap = (timer == 32'hFFFFFFFF) && !tmr_we;

  // Entering COUNTING is the first stable sample, so acceptance happens as the
  // count steps to DEB_CYCLES-1, giving DEB_CYCLES stable samples in total.
  assign cnt_next = cnt + 20'd1;
  assign deb_done = (cnt_next >= (DEB_CYCLES - 20'd1));

  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[ram_idx] <= ram_dat_i_w;
    end
  end

  always_comb begin
    ram_dat_o_w = '0;
    if (!io_sel) begin
      ram_dat_o_w = mem[ram_idx];
    end else begin
      case (ram_adr_i_w)
        LED_ADR:  ram_dat_o_w = {16'h0000, led_o};
        SW_ADR:   ram_dat_o_w = {16'h0000, sw_reg};
        TMR_ADR:  ram_dat_o_w = timer;
        STAT_ADR: ram_dat_o_w = {31'h0, tmr_ovf_o};
        default:  ram_dat_o_w = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_o <= '0;
    end else if (led_we) begin
      led_o <= ram_dat_i_w[15:0];
    end
  end

  // A wrap on the same edge as a STATUS clear keeps the flag set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer     <= '0;
      tmr_ovf_o <= 1'b0;
    end else begin
      timer <= tmr_we ? ram_dat_i_w : timer + 32'd1;
      if (tmr_wrap) begin
        tmr_ovf_o <= 1'b1;
      end else if (stat_we) begin
        tmr_ovf_o <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1  <= '0;
      sync2  <= '0;
      cand   <= '0;
      sw_reg <= '0;
      cnt    <= '0;
      state  <= STABLE;
    end else begin
      sync1 <= sw_i;
      sync2 <= sync1;
      case (state)
        STABLE: begin
          if (sync2 != sw_reg) begin
            state <= COUNTING;
            cnt   <= '0;
            cand  <= sync2;
          end
        end
        COUNTING: begin
          if (sync2 != cand) begin
            cand <= sync2;
            cnt  <= '0;
          end else if (deb_done) begin
            sw_reg <= cand;
            cnt    <= '0;
            state  <= STABLE;
          end else begin
            cnt <= cnt_next;
          end
        end
        default: state <= STABLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_io.sv
`default_nettype none
// tb_data_mem_io: vector table with a scoreboard queue, plus hand sequences for timer, debounce and reset.
module tb_data_mem_io;

  localparam logic [31:0] IOB  = 32'hFFFFFC00;
  localparam logic [31:0] LED  = IOB + 32'h60;
  localparam logic [31:0] SWA  = IOB + 32'h70;
  localparam logic [31:0] TMR  = IOB + 32'h80;
  localparam logic [31:0] STAT = IOB + 32'h84;

  logic        clk;
  logic        reset;
  logic        ram_wen_w;
  logic [31:0] ram_adr_i_w;
  logic [31:0] ram_dat_i_w;
  logic [31:0] ram_dat_o_w;
  logic [15:0] sw_i;
  logic [15:0] led_o;
  logic        tmr_ovf_o;

  int checks;
  int failures;

  data_mem_io #(
    .ADDR_W    (14),
    .IO_BASE   (IOB),
    .DEB_CYCLES(20'd8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ram_wen_w  (ram_wen_w),
    .ram_adr_i_w(ram_adr_i_w),
    .ram_dat_i_w(ram_dat_i_w),
    .ram_dat_o_w(ram_dat_o_w),
    .sw_i       (sw_i),
    .led_o      (led_o),
    .tmr_ovf_o  (tmr_ovf_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        wen;
    logic [31:0] adr;
    logic [31:0] din;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        chk_led;
    logic [15:0] exp_led;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  function automatic vec_t mk(input string n, input logic w, input logic [31:0] a,
                              input logic [31:0] d, input logic cr, input logic [31:0] er,
                              input logic cl, input logic [15:0] el);
    vec_t v;
    v.name = n; v.wen = w; v.adr = a; v.din = d;
    v.chk_rd = cr; v.exp_rd = er; v.chk_led = cl; v.exp_led = el;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    ram_wen_w   = w;
    ram_adr_i_w = a;
    ram_dat_i_w = d;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vec_t e;
    checks = 0;
    failures = 0;
    reset = 1'b0;
    ram_wen_w = 1'b0;
    ram_adr_i_w = '0;
    ram_dat_i_w = '0;
    sw_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_led", {16'h0, led_o}, 32'h0);
    check("rst_ovf", {31'h0, tmr_ovf_o}, 32'h0);

    // Timer counts cycles from the release of reset.
    @(negedge clk);
    reset = 1'b1;
    ram_adr_i_w = TMR;
    #1;
    check("tmr_k0", ram_dat_o_w, 32'd0);
    for (int k = 1; k < 5; k++) begin
      @(negedge clk);
      #1;
      check($sformatf("tmr_k%0d", k), ram_dat_o_w, k);
    end

    vecs.push_back(mk("sw10",     1, 32'h10,       32'hDEADBEEF, 0, 0,            0, 0));
    vecs.push_back(mk("lw10",     0, 32'h10,       0,            1, 32'hDEADBEEF, 0, 0));
    vecs.push_back(mk("lw12",     0, 32'h12,       0,            1, 32'hDEADBEEF, 0, 0));
    vecs.push_back(mk("lw10010",  0, 32'h10010,    0,            1, 32'hDEADBEEF, 0, 0));
    vecs.push_back(mk("sw20_5",   1, 32'h20,       32'd5,        0, 0,            0, 0));
    vecs.push_back(mk("sw20_9",   1, 32'h20,       32'd9,        1, 32'd5,        0, 0));
    vecs.push_back(mk("lw20",     0, 32'h20,       0,            1, 32'd9,        0, 0));
    vecs.push_back(mk("sw_led",   1, LED,          32'h1234A5A5, 0, 0,            1, 16'hA5A5));
    vecs.push_back(mk("lw_led",   0, LED,          0,            1, 32'h0000A5A5, 1, 16'hA5A5));
    vecs.push_back(mk("sw_unmap", 1, IOB + 32'h64, 32'hFFFFFFFF, 1, 32'h0,        1, 16'hA5A5));
    vecs.push_back(mk("lw_unmap", 0, IOB + 32'h64, 0,            1, 32'h0,        1, 16'hA5A5));
    vecs.push_back(mk("sw_swreg", 1, SWA,          32'h0000FFFF, 0, 0,            1, 16'hA5A5));
    vecs.push_back(mk("lw_swreg", 0, SWA,          0,            1, 32'h0,        0, 0));
    vecs.push_back(mk("sw_fc00",  1, 32'hFC00,     32'h11,       0, 0,            0, 0));
    vecs.push_back(mk("sw_iob",   1, IOB,          32'hAB,       0, 0,            0, 0));
    vecs.push_back(mk("lw_fc00",  0, 32'hFC00,     0,            1, 32'h11,       0, 0));
    vecs.push_back(mk("lw_iob",   0, IOB,          0,            1, 32'h0,        0, 0));
    vecs.push_back(mk("sw_below", 1, IOB - 32'h4,  32'h77,       0, 0,            0, 0));
    vecs.push_back(mk("lw_below", 0, IOB - 32'h4,  0,            1, 32'h77,       0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].wen, vecs[i].adr, vecs[i].din);
      sb.push_back(vecs[i]);
      #1;
      e = sb.pop_front();
      if (e.chk_rd) check(e.name, ram_dat_o_w, e.exp_rd);
      after_edge();
      if (e.chk_led) check({e.name, "_led"}, {16'h0, led_o}, {16'h0, e.exp_led});
    end
    drive(0, 0, 0);

    // Wrap two cycles after loading FFFF_FFFE.
    drive(1, TMR, 32'hFFFFFFFE);
    drive(0, TMR, 0);
    #1;
    check("wrap_m1", ram_dat_o_w, 32'hFFFFFFFE);
    drive(0, TMR, 0);
    #1;
    check("wrap_max", ram_dat_o_w, 32'hFFFFFFFF);
    check("wrap_ovf0", {31'h0, tmr_ovf_o}, 32'h0);
    drive(0, TMR, 0);
    #1;
    check("wrap_zero", ram_dat_o_w, 32'h0);
    check("wrap_ovf1", {31'h0, tmr_ovf_o}, 32'h1);
    drive(0, STAT, 0);
    #1;
    check("stat_rd", ram_dat_o_w, 32'h1);
    drive(1, STAT, 32'h123);
    after_edge();
    check("stat_clr", {31'h0, tmr_ovf_o}, 32'h0);

    // STATUS clear on the wrap edge: set wins.
    drive(1, TMR, 32'hFFFFFFFE);
    drive(0, TMR, 0);
    drive(1, STAT, 0);
    after_edge();
    check("set_wins", {31'h0, tmr_ovf_o}, 32'h1);
    drive(1, STAT, 0);
    after_edge();
    check("late_clr", {31'h0, tmr_ovf_o}, 32'h0);

    // Loading FFFF_FFFF does not set the flag; the next increment does.
    drive(1, TMR, 32'hFFFFFFFF);
    drive(0, TMR, 0);
    #1;
    check("ld_max_rd", ram_dat_o_w, 32'hFFFFFFFF);
    check("ld_max_ovf", {31'h0, tmr_ovf_o}, 32'h0);
    after_edge();
    check("ld_inc_ovf", {31'h0, tmr_ovf_o}, 32'h1);
    drive(0, TMR, 0);
    #1;
    check("ld_inc_rd", ram_dat_o_w, 32'h0);

    // Debounce: accepted 10 edges after the change.
    @(negedge clk);
    ram_wen_w = 1'b0;
    ram_adr_i_w = SWA;
    sw_i = 16'h0003;
    for (int j = 1; j <= 12; j++) begin
      after_edge();
      check($sformatf("deb_e%0d", j), ram_dat_o_w, (j >= 10) ? 32'h3 : 32'h0);
    end
    @(negedge clk);
    sw_i = 16'h0000;
    repeat (14) after_edge();
    check("deb_back0", ram_dat_o_w, 32'h0);

    // Glitch before edges 4 and 6: last change before edge 7, accepted at edge 16.
    for (int j = 1; j <= 18; j++) begin
      @(negedge clk);
      sw_i = (j == 4 || j == 6) ? 16'h0000 : 16'h0003;
      after_edge();
      check($sformatf("glitch_e%0d", j), ram_dat_o_w, (j >= 16) ? 32'h3 : 32'h0);
    end

    // Asynchronous reset between edges with state live.
    drive(1, LED, 32'h0000FFFF);
    after_edge();
    check("pre_rst_led", {16'h0, led_o}, 32'h0000FFFF);
    check("pre_rst_ovf", {31'h0, tmr_ovf_o}, 32'h1);
    @(negedge clk);
    ram_wen_w = 1'b0;
    sw_i = 16'h0005;
    repeat (5) @(posedge clk);
    @(negedge clk);
    #2;
    reset = 1'b0;
    ram_adr_i_w = TMR;
    #1;
    check("rst_mid_led", {16'h0, led_o}, 32'h0);
    check("rst_mid_ovf", {31'h0, tmr_ovf_o}, 32'h0);
    check("rst_mid_tmr", ram_dat_o_w, 32'h0);
    ram_adr_i_w = SWA;
    #1;
    check("rst_mid_sw", ram_dat_o_w, 32'h0);
    ram_wen_w = 1'b1;
    ram_adr_i_w = 32'h10;
    ram_dat_i_w = 32'h0;
    after_edge();
    @(negedge clk);
    ram_wen_w = 1'b0;
    ram_adr_i_w = SWA;
    reset = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      after_edge();
      check($sformatf("rel_deb_e%0d", j), ram_dat_o_w, (j >= 10) ? 32'h5 : 32'h0);
    end
    drive(0, 32'h10, 0);
    #1;
    check("ram_kept", ram_dat_o_w, 32'hDEADBEEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/data_mem_io.md
Name: data_mem_io

Overview:
Responder end of the CPU data-memory port. Serves lw/sw from the pipeline's EX/MEM stage with a word-addressed RAM and a small memory-mapped I/O window holding an LED register, debounced switches and a cycle timer. Read data is returned combinationally in the same cycle as the address, because the pipeline captures read data into MEM/WB at the next edge. Writes commit at the clock edge.

Parameters:
ADDR_W, 14, RAM word-address width; RAM depth = 2^ADDR_W 32-bit words.
IO_BASE, 32'hFFFFFC00, start of the I/O window; any address >= IO_BASE is I/O.
DEB_CYCLES, 20'd1000000, cycles a synchronised switch value must stay stable before it is accepted.

Ports:
clk  input  1  single clock; all state on rising edge.
reset  input  1  asynchronous, active-low reset.
ram_wen_w  input  1  write enable from the CPU, sampled at the rising edge.
ram_adr_i_w  input  32  byte address; bits [1:0] ignored.
ram_dat_i_w  input  32  write data.
ram_dat_o_w  output  32  read data, combinational from the current address.
sw_i  input  16  raw asynchronous switch inputs.
led_o  output  16  LED register.
tmr_ovf_o  output  1  sticky timer-overflow flag.

Behaviour:
- Decode: io_sel = (ram_adr_i_w >= IO_BASE). RAM index = ram_adr_i_w[ADDR_W+1:2]. RAM address bits above ADDR_W+1 are ignored, so the RAM aliases.
- I/O map (full 32-bit match):
  - IO_BASE+0x60: LED. Read and write; only bits [15:0] are stored; reads are zero-extended.
  - IO_BASE+0x70: SW. Read-only debounced value, zero-extended; writes are ignored.
  - IO_BASE+0x80: TIMER. Read and write.
  - IO_BASE+0x84: STATUS. Bit 0 = overflow flag; a write of any value clears it.
  - Any other I/O address reads 0; writes to it are ignored.
- Read path: ram_dat_o_w is combinational. On a write and read of the same address in the same cycle, the read returns the pre-edge value.
- Write path: when ram_wen_w=1 at the rising edge, the selected RAM word or I/O register takes ram_dat_i_w.
- Timer:
  - 32-bit counter, increments by 1 every cycle.
  - A TIMER write loads ram_dat_i_w; the load takes priority over the increment.
  - Wrap: 32'hFFFFFFFF -> 0 sets the overflow flag.
  - Overflow and a STATUS clear in the same edge: set wins, flag = 1.
  - Loading 32'hFFFFFFFF does not set the flag; the following increment does.
- Switch path:
  - Two-flop synchroniser sync2, then a debounce FSM with states STABLE and COUNTING.
  - STABLE: if sync2 != sw_reg, go to COUNTING with cnt=0 and cand=sync2.
  - COUNTING: if sync2 != cand, set cand=sync2 and cnt=0. Otherwise cnt++.
  - When cnt reaches DEB_CYCLES-1: sw_reg=cand, return to STABLE.
  - Latency from an sw_i change to SW readback is 2 + DEB_CYCLES cycles.
- Reset (reset=0, asynchronous) clears led_o=0, timer=0, tmr_ovf_o=0, sync flops, sw_reg=0, cnt=0, FSM=STABLE.
  - RAM contents are not reset; RAM writes are blocked while reset=0.
  - A mid-debounce reset abandons the candidate value.
- tmr_ovf_o mirrors STATUS bit 0. led_o mirrors the LED register.
- Implementation target: distributed RAM with asynchronous read. No byte enables; all accesses are full-word.

Test Plan:
- RAM write/read: sw 32'hDEADBEEF to 0x0000_0010, then lw 0x10 -> 32'hDEADBEEF. lw 0x0000_0012 -> same word. With ADDR_W=14, lw 0x0001_0010 -> aliases to the same word.
- LED and unmapped I/O:
  - Write 32'h1234_A5A5 to IO_BASE+0x60 -> led_o=16'hA5A5, readback 32'h0000_A5A5.
  - Write to IO_BASE+0x64 -> no change; read -> 0.
- Timer: after reset, read TIMER at cycle k -> k.
  - Write 32'hFFFF_FFFE -> two cycles later the timer wraps to 0 and tmr_ovf_o=1.
  - Write STATUS on the same edge as a wrap -> flag stays 1.
  - A later STATUS write -> flag 0.
- Debounce (DEB_CYCLES=8):
  - sw_i=16'h0003 held -> SW reads 0 until 10 cycles after the change, then 16'h0003.
  - A glitch toggling for 3 cycles mid-count -> the count restarts; the value is accepted only after 8 stable cycles.
- Same-cycle write and read of RAM 0x20 (old 5, new 9) -> ram_dat_o_w=5 before the edge, 9 after.
- Reset mid-operation:
  - Assert reset between edges with led_o=16'hFFFF, timer running, debounce counting -> led_o, timer, tmr_ovf_o and SW go to 0 immediately.
  - A RAM word written before reset is still readable after release.
